// File: rtl/pll_cfg_writer_if.sv
// Avalon-MM management bus between the PLL config sequencer and the PLL reconfig block.
interface pll_cfg_writer_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_write, mgmt_read, mgmt_writedata,
        output mgmt_readdata, mgmt_waitrequest
    );
endinterface

// File: rtl/pll_cfg_writer.sv
// PLL reconfiguration sequencer: writes mode and counter words to the reconfig
// block, triggers the update, polls status and waits for a stable lock.
module pll_cfg_writer #(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [17:0]       cfg_n,
    input  logic [17:0]       cfg_m,
    input  logic [17:0]       cfg_c0,
    input  logic [17:0]       cfg_c1,
    output logic              busy,
    output logic              done,
    output logic              error,
    input  logic              pll_locked,
    pll_cfg_writer_if.master  mgmt
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE);

    typedef enum logic [3:0] {
        IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_C1, WR_START, RD_STATUS, WAIT_LOCK, DONE
    } state_t;

    state_t      state, state_nx;
    logic [17:0] sh_n, sh_m, sh_c0, sh_c1;
    logic        locked_meta, locked_sync;
    logic [TW-1:0] tcnt, tcnt_nx, tcnt_inc;
    logic [SW-1:0] scnt, scnt_nx, scnt_inc;
    logic        error_nx;
    logic        accept;
    logic        write_nx, read_nx;
    logic [5:0]  addr_nx;
    logic [31:0] wdata_nx;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    state_t      wr_next;
    logic        unused_rdata;

    // Only bit 0 of the status register carries information.
    assign unused_rdata = ^mgmt.mgmt_readdata[31:1];

    function automatic logic [TW-1:0] sat_inc_timeout(input logic [TW-1:0] v);
        return (v == TIMEOUT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [SW-1:0] sat_inc_stable(input logic [SW-1:0] v);
        return (v == STABLE_MAX) ? v : v + 1'b1;
    endfunction

    assign tcnt_inc = sat_inc_timeout(tcnt);
    assign scnt_inc = sat_inc_stable(scnt);
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Two-flop synchroniser for the asynchronous PLL lock indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_sync <= locked_meta;
        end
    end

    // Shadow copy of the counter words, captured when a request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_n  <= cfg_n;
            sh_m  <= cfg_m;
            sh_c0 <= cfg_c0;
            sh_c1 <= cfg_c1;
        end
    end

    // Registered bus outputs, counters and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mgmt.mgmt_write     <= 1'b0;
            mgmt.mgmt_read      <= 1'b0;
            mgmt.mgmt_address   <= 6'd0;
            mgmt.mgmt_writedata <= 32'd0;
            tcnt                <= '0;
            scnt                <= '0;
            error               <= 1'b0;
        end else begin
            mgmt.mgmt_write     <= write_nx;
            mgmt.mgmt_read      <= read_nx;
            mgmt.mgmt_address   <= addr_nx;
            mgmt.mgmt_writedata <= wdata_nx;
            tcnt                <= tcnt_nx;
            scnt                <= scnt_nx;
            error               <= error_nx;
        end
    end

    // Register-write table: address, data and successor for each write state.
    always_comb begin
        wr_addr = 6'd0;
        wr_data = 32'd0;
        wr_next = IDLE;
        case (state)
            WR_MODE:  begin wr_addr = 6'd0; wr_data = 32'd1;                    wr_next = WR_N;      end
            WR_N:     begin wr_addr = 6'd3; wr_data = {14'b0, sh_n};            wr_next = WR_M;      end
            WR_M:     begin wr_addr = 6'd4; wr_data = {14'b0, sh_m};            wr_next = WR_C0;     end
            WR_C0:    begin wr_addr = 6'd5; wr_data = {9'b0, 5'd0, sh_c0};      wr_next = WR_C1;     end
            WR_C1:    begin wr_addr = 6'd5; wr_data = {9'b0, 5'd1, sh_c1};      wr_next = WR_START;  end
            WR_START: begin wr_addr = 6'd2; wr_data = 32'd0;                    wr_next = RD_STATUS; end
            default:  ;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        write_nx = mgmt.mgmt_write;
        read_nx  = mgmt.mgmt_read;
        addr_nx  = mgmt.mgmt_address;
        wdata_nx = mgmt.mgmt_writedata;
        tcnt_nx  = tcnt;
        scnt_nx  = scnt;
        error_nx = error;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    error_nx = 1'b0;
                    state_nx = WR_MODE;
                end
            end
            RD_STATUS: begin
                tcnt_nx = tcnt_inc;
                if (tcnt_inc == TIMEOUT_MAX) begin
                    // Give up: drop any outstanding read and report failure.
                    read_nx  = 1'b0;
                    error_nx = 1'b1;
                    state_nx = DONE;
                end else if (!mgmt.mgmt_read) begin
                    read_nx = 1'b1;
                    addr_nx = 6'd1;
                end else if (!mgmt.mgmt_waitrequest) begin
                    read_nx = 1'b0;
                    if (mgmt.mgmt_readdata[0]) state_nx = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                tcnt_nx = tcnt_inc;
                scnt_nx = locked_sync ? scnt_inc : '0;
                if (tcnt_inc == TIMEOUT_MAX) begin
                    error_nx = 1'b1;
                    state_nx = DONE;
                end else if (locked_sync && (scnt_inc == STABLE_MAX)) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: begin
                // Write states: raise the strobe, hold it through waitrequest,
                // drop it after completion so an idle cycle separates transfers.
                if (!mgmt.mgmt_write) begin
                    write_nx = 1'b1;
                    addr_nx  = wr_addr;
                    wdata_nx = wr_data;
                end else if (!mgmt.mgmt_waitrequest) begin
                    write_nx = 1'b0;
                    state_nx = wr_next;
                    if (state == WR_START) begin
                        tcnt_nx = '0;
                        scnt_nx = '0;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_pll_cfg_writer.sv
// Directed bench for pll_cfg_writer with an Avalon slave model and a write scoreboard.
module tb_pll_cfg_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c0 = '0, cfg_c1 = '0;
    logic        busy, done, error;
    logic        pll_locked = 1'b0;

    pll_cfg_writer_if mgmt();

    pll_cfg_writer #(.LOCK_TIMEOUT(100), .LOCK_STABLE(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1),
        .busy(busy), .done(done), .error(error),
        .pll_locked(pll_locked), .mgmt(mgmt)
    );

    typedef struct packed { logic [5:0] addr; logic [31:0] data; } xfer_t;
    xfer_t sb[$];
    xfer_t exp_x;

    int errors = 0, checks = 0;
    int cyc = 0;
    int wait_cfg = 0, notready = 0, poll_idx = 0;
    int wr_cnt = 0, rd_cnt = 0;
    int st_cyc = 0, rd_ok_cyc = 0, done_cyc = 0;
    logic rd_ok_seen = 0, done_seen = 0, done_err = 0, done_busy = 0;
    int stall_cnt = 0;
    logic prev_stall = 0, prev_cmp = 0, strobe, ready;
    logic [5:0] sv_addr;
    logic [31:0] sv_data;
    logic [1:0] sv_st;
    int rise_cyc;
    logic found;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Slave model and bus monitor, acting on the falling edge.
    initial begin
        mgmt.mgmt_waitrequest = 1'b0;
        mgmt.mgmt_readdata    = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_cnt = 0; prev_stall = 0; prev_cmp = 0;
                mgmt.mgmt_waitrequest = 1'b0;
            end else begin
                strobe = mgmt.mgmt_write | mgmt.mgmt_read;
                if (prev_cmp) check("idle_gap", strobe, 1'b0);
                if (prev_stall) begin
                    check("hold_addr", mgmt.mgmt_address, sv_addr);
                    check("hold_data", mgmt.mgmt_writedata, sv_data);
                    check("hold_strobe", {mgmt.mgmt_write, mgmt.mgmt_read}, sv_st);
                end
                if (strobe && stall_cnt < wait_cfg) begin
                    mgmt.mgmt_waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    mgmt.mgmt_waitrequest = 1'b0;
                end
                prev_stall = strobe && mgmt.mgmt_waitrequest;
                prev_cmp   = strobe && !mgmt.mgmt_waitrequest;
                sv_addr = mgmt.mgmt_address;
                sv_data = mgmt.mgmt_writedata;
                sv_st   = {mgmt.mgmt_write, mgmt.mgmt_read};
                if (prev_cmp) begin
                    stall_cnt = 0;
                    if (mgmt.mgmt_write) begin
                        wr_cnt++;
                        if (mgmt.mgmt_address == 6'd2) st_cyc = cyc + 1;
                        check("sb_has_entry", (sb.size() != 0), 1'b1);
                        if (sb.size() != 0) begin
                            exp_x = sb.pop_front();
                            check("wr_addr", mgmt.mgmt_address, exp_x.addr);
                            check("wr_data", mgmt.mgmt_writedata, exp_x.data);
                        end
                    end else begin
                        check("rd_addr", mgmt.mgmt_address, 6'd1);
                        ready = (poll_idx >= notready);
                        mgmt.mgmt_readdata = {31'b0, ready};
                        poll_idx++;
                        rd_cnt++;
                        if (ready) begin
                            rd_ok_seen = 1'b1;
                            rd_ok_cyc  = cyc + 1;
                        end
                    end
                end
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_err  = error;
                done_busy = busy;
            end
        end
    end

    // Queue the six expected register writes and issue a one-cycle start.
    task automatic launch(input logic [17:0] n, input logic [17:0] m,
                          input logic [17:0] c0, input logic [17:0] c1);
        sb.push_back('{6'd0, 32'd1});
        sb.push_back('{6'd3, {14'b0, n}});
        sb.push_back('{6'd4, {14'b0, m}});
        sb.push_back('{6'd5, {9'b0, 5'd0, c0}});
        sb.push_back('{6'd5, {9'b0, 5'd1, c1}});
        sb.push_back('{6'd2, 32'd0});
        wr_cnt = 0; rd_cnt = 0; poll_idx = 0;
        rd_ok_seen = 0; done_seen = 0;
        cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_c1 = c1;
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        cfg_n = ~n; cfg_m = ~m; cfg_c0 = ~c0; cfg_c1 = ~c1;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) begin
            @(negedge clk); #2;
        end
        check("done_seen", done_seen, 1'b1);
    endtask

    task automatic wait_rd_ok(input int budget);
        for (int i = 0; i < budget && !rd_ok_seen; i++) begin
            @(negedge clk); #2;
        end
        check("status_ready_seen", rd_ok_seen, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_write", mgmt.mgmt_write, 1'b0);
        check("rst_read", mgmt.mgmt_read, 1'b0);
        check("rst_addr", mgmt.mgmt_address, 6'd0);
        check("rst_wdata", mgmt.mgmt_writedata, 32'd0);
        rst = 1'b0;
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        #2;

        // Zero-wait slave, immediate status, lock already high
        wait_cfg = 0; notready = 0;
        launch(18'h10000, 18'h00B0B, 18'h00303, 18'h00303);
        wait_done(300);
        check("t1_writes", wr_cnt, 6);
        check("t1_reads", rd_cnt, 1);
        check("t1_stable_cycles", done_cyc - rd_ok_cyc, 16);
        check("t1_error", done_err, 1'b0);
        check("t1_busy_at_done", done_busy, 1'b0);
        check("t1_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        #2;

        // Three-cycle waitrequest on every transfer
        wait_cfg = 3;
        launch(18'h2A5A5, 18'h15A5A, 18'h0F00F, 18'h30C30);
        wait_done(400);
        check("t2_writes", wr_cnt, 6);
        check("t2_error", done_err, 1'b0);
        check("t2_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        #2;

        // Status not ready for five polls
        wait_cfg = 0; notready = 5;
        launch(18'h00101, 18'h00202, 18'h20404, 18'h10808);
        wait_done(400);
        check("t3_reads", rd_cnt, 6);
        check("t3_error", done_err, 1'b0);
        check("t3_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        #2;

        // Lock never arrives: timeout
        notready = 0;
        pll_locked = 1'b0;
        launch(18'h00011, 18'h00022, 18'h00033, 18'h00044);
        wait_done(400);
        check("t4_timeout_cycles", done_cyc - st_cyc, 100);
        check("t4_error", done_err, 1'b1);
        check("t4_busy_at_done", done_busy, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        check("t4_error_held", error, 1'b1);
        check("t4_busy_idle", busy, 1'b0);
        pll_locked = 1'b1;
        repeat (4) @(negedge clk);
        #2;

        // Lock glitch part-way through the stable window
        launch(18'h01234, 18'h04321, 18'h00505, 18'h00606);
        check("t5_error_cleared", error, 1'b0);
        wait_rd_ok(300);
        repeat (8) @(negedge clk);
        #2;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        pll_locked = 1'b1;
        rise_cyc = cyc;
        wait_done(300);
        check("t5_restart_cycles", done_cyc - rise_cyc, 18);
        check("t5_error", done_err, 1'b0);
        repeat (2) @(negedge clk);
        #2;

        // Reset while WR_M is stalled, then a clean full sequence
        wait_cfg = 3;
        launch(18'h3FFFF, 18'h2AAAA, 18'h15555, 18'h00F0F);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk); #2;
            if (mgmt.mgmt_write && mgmt.mgmt_address == 6'd4 && mgmt.mgmt_waitrequest) found = 1'b1;
        end
        check("t6_wr_m_stall_seen", found, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_write_dropped", mgmt.mgmt_write, 1'b0);
        check("t6_read_low", mgmt.mgmt_read, 1'b0);
        check("t6_busy_dropped", busy, 1'b0);
        @(negedge clk); #2;
        rst = 1'b0;
        sb.delete();
        wait_cfg = 0;
        repeat (3) @(negedge clk);
        #2;
        launch(18'h00777, 18'h00888, 18'h00999, 18'h00AAA);
        wait_done(300);
        check("t6_writes", wr_cnt, 6);
        check("t6_error", done_err, 1'b0);
        check("t6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
